path_result_monitor: RTL and testbench

Downstream consumer of the multi-path clock stage's 32-bit result word: four 8-bit lanes, `{merged_or, merged_sel, cross, a1^b1}` from MSB to LSB. The block folds a fixed-length window of accepted words into one 8-bit rotate-XOR signature per lane and flags which lanes toggled during the window. It presents the packed result on a valid/ready handshake. Used by the DSP bring-up bench and the on-chip self-check path to confirm every clock path is alive.

---
 rtl/path_mon_pkg.sv | 32 +++
 rtl/path_result_monitor_if.sv | 40 ++++
 rtl/path_lane_sig.sv | 56 +++++
 rtl/path_result_monitor.sv | 160 ++++++++++++++++
 tb/tb_path_result_monitor.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/path_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : path_mon_pkg
//  Description : Shared types, lane geometry and the signature step function
//                for the path result monitor.
//  Contents    : state_t  - monitor FSM state (IDLE/ACCUM/REPORT)
//                LANES    - number of 8-bit lanes in a result word
//                LANE_W   - lane width in bits
//                sig_step - rotate-left-by-1 then XOR in a new byte
//  Revision    : 1.0 - initial release
// ============================================================================
package path_mon_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    // Carry-free fold: rotate the running signature left by one, XOR the byte.
    function automatic logic [LANE_W-1:0] sig_step(
        input logic [LANE_W-1:0] sig,
        input logic [LANE_W-1:0] data
    );
        return {sig[LANE_W-2:0], sig[LANE_W-1]} ^ data;
    endfunction

endpackage : path_mon_pkg
`default_nettype wire

// File: rtl/path_result_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : path_result_monitor_if
//  Description : Word-input / signature-output handshake bundle of the path
//                result monitor.
//  Signals     : start           - one-cycle pulse, opens a window
//                in_valid/in_ready/in_data      - result word stream (32 bit)
//                sig_valid/sig_ready/sig_data   - per-lane signature result
//                sig_lane_active - bit k: lane k changed within the window
//                busy            - monitor not idle
//                overrun         - sticky, word offered while reporting
//  Modports    : master - word producer / result consumer
//                slave  - the monitor
//  Revision    : 1.0 - initial release
// ============================================================================
interface path_result_monitor_if;

    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        sig_valid;
    logic        sig_ready;
    logic [31:0] sig_data;
    logic [3:0]  sig_lane_active;
    logic        busy;
    logic        overrun;

    modport master (
        output start, in_valid, in_data, sig_ready,
        input  in_ready, sig_valid, sig_data, sig_lane_active, busy, overrun
    );

    modport slave (
        input  start, in_valid, in_data, sig_ready,
        output in_ready, sig_valid, sig_data, sig_lane_active, busy, overrun
    );

endinterface : path_result_monitor_if
`default_nettype wire

// File: rtl/path_lane_sig.sv
`default_nettype none
// ============================================================================
//  Module      : path_lane_sig
//  Description : One lane of the monitor: rotate-XOR signature register,
//                previous accepted byte and a sticky "lane changed" flag.
//  Ports       : clk      - block clock
//                rst_n    - synchronous active-low reset
//                i_clr    - clear signature, previous byte and flag
//                i_en     - fold i_byte in (one accepted word)
//                i_first  - this is the first word of the window
//                i_byte   - this lane's byte of the accepted word
//                o_sig    - current signature
//                o_active - lane changed at least once in the window
//  Revision    : 1.0 - initial release
// ============================================================================
module path_lane_sig
    import path_mon_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_clr,
    input  wire logic              i_en,
    input  wire logic              i_first,
    input  wire logic [LANE_W-1:0] i_byte,
    output logic      [LANE_W-1:0] o_sig,
    output logic                   o_active
);

    logic [LANE_W-1:0] r_sig;
    logic [LANE_W-1:0] r_prev;
    logic              r_active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sig    <= '0;
            r_prev   <= '0;
            r_active <= 1'b0;
        end else if (i_clr) begin
            r_sig    <= '0;
            r_prev   <= '0;
            r_active <= 1'b0;
        end else if (i_en) begin
            r_sig  <= sig_step(r_sig, i_byte);
            r_prev <= i_byte;
            // The first word has no predecessor, so it can never flag a change.
            if (!i_first && (i_byte != r_prev)) begin
                r_active <= 1'b1;
            end
        end
    end

    assign o_sig    = r_sig;
    assign o_active = r_active;

endmodule : path_lane_sig
`default_nettype wire

// File: rtl/path_result_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : path_result_monitor
//  Description : Folds a window of WINDOW_LEN accepted 32-bit result words
//                into four 8-bit rotate-XOR lane signatures plus per-lane
//                toggle flags, and presents them on a valid/ready handshake.
//  Parameters  : WINDOW_LEN - words per window, 2..256
//  Ports       : clk_in - block clock
//                rst_n  - synchronous active-low reset
//                bus    - path_result_monitor_if.slave (stream in, result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module path_result_monitor
    import path_mon_pkg::*;
#(
    parameter int WINDOW_LEN = 16
) (
    input  wire logic             clk_in,
    input  wire logic             rst_n,
    path_result_monitor_if.slave  bus
);

    localparam int              CNT_W  = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WINDOW_LEN - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_count;
    logic                     r_overrun;

    logic                     w_accept;
    logic                     w_clear;
    logic                     w_fold;
    logic                     w_last;
    logic                     w_first;
    logic                     w_in_ready;
    logic                     w_sig_valid;
    logic                     w_busy;
    logic [LANES*LANE_W-1:0]  w_lane_sig;
    logic [LANES-1:0]         w_lane_active;

    // start is honoured in IDLE and ACCUM only; REPORT ignores it.
    assign w_clear  = bus.start && (r_state == ST_IDLE || r_state == ST_ACCUM);
    assign w_accept = bus.in_valid && (r_state == ST_ACCUM);
    // A word arriving together with a restart is discarded.
    assign w_fold   = w_accept && !bus.start;
    assign w_last   = w_fold && (r_count == c_LAST);
    assign w_first  = (r_count == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (!bus.start && w_last) begin
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (bus.sig_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_sig_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            ST_REPORT: begin
                w_sig_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: begin
                w_in_ready  = 1'b0;
                w_sig_valid = 1'b0;
                w_busy      = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word counter: returns to zero after the last word of the window
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_clear) begin
            r_count <= '0;
        end else if (w_fold) begin
            r_count <= w_last ? '0 : (r_count + CNT_W'(1));
        end
    end

    // ------------------------------------------------------------------
    // Sticky overrun: a word offered while the result is being reported
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_clear) begin
            r_overrun <= 1'b0;
        end else if ((r_state == ST_REPORT) && bus.in_valid) begin
            r_overrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Lane signature datapath
    // ------------------------------------------------------------------
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        path_lane_sig u_lane (
            .clk      (clk_in),
            .rst_n    (rst_n),
            .i_clr    (w_clear),
            .i_en     (w_fold),
            .i_first  (w_first),
            .i_byte   (bus.in_data[k*LANE_W +: LANE_W]),
            .o_sig    (w_lane_sig[k*LANE_W +: LANE_W]),
            .o_active (w_lane_active[k])
        );
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.sig_valid       = w_sig_valid;
    assign bus.busy            = w_busy;
    assign bus.overrun         = r_overrun;
    assign bus.sig_data        = w_lane_sig;
    assign bus.sig_lane_active = w_lane_active;

endmodule : path_result_monitor
`default_nettype wire

// File: tb/tb_path_result_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_path_result_monitor
//  Description : Self-checking bench for path_result_monitor (WINDOW_LEN=4).
//                A window-level reference model (queue of accepted words,
//                signature recomputed from the whole queue) predicts every
//                output after every clock; directed scenarios add fixed
//                expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_path_result_monitor;

    localparam int WL = 4;

    logic clk_in;
    logic rst_n;

    path_result_monitor_if u_if ();

    path_result_monitor #(
        .WINDOW_LEN (WL)
    ) u_dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (u_if.slave)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mode;       // 0 idle, 1 collecting, 2 reporting
    logic [31:0] m_words[$];   // words accepted in the current window
    logic        m_ovr;

    function automatic logic [31:0] ref_sig();
        logic [31:0] res;
        logic [31:0] w;
        logic [7:0]  s;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            s = 8'h00;
            for (int i = 0; i < m_words.size(); i++) begin
                w = m_words[i];
                s = {s[6:0], s[7]} ^ w[8*k +: 8];
            end
            res[8*k +: 8] = s;
        end
        return res;
    endfunction

    function automatic logic [3:0] ref_act();
        logic [3:0]  a;
        logic [31:0] cur;
        logic [31:0] prv;
        a = '0;
        for (int i = 1; i < m_words.size(); i++) begin
            cur = m_words[i];
            prv = m_words[i-1];
            for (int k = 0; k < 4; k++) begin
                if (cur[8*k +: 8] != prv[8*k +: 8]) a[k] = 1'b1;
            end
        end
        return a;
    endfunction

    task automatic model_step(input logic st, input logic iv, input logic [31:0] d,
                              input logic sr, input logic rn);
        if (!rn) begin
            m_mode = 0;
            m_words.delete();
            m_ovr = 1'b0;
        end else begin
            case (m_mode)
                0: if (st) begin
                    m_mode = 1;
                    m_words.delete();
                    m_ovr = 1'b0;
                end
                1: if (st) begin
                    m_words.delete();
                    m_ovr = 1'b0;
                end else if (iv) begin
                    m_words.push_back(d);
                    if (m_words.size() == WL) m_mode = 2;
                end
                default: begin
                    if (iv) m_ovr = 1'b1;
                    if (sr) m_mode = 0;
                end
            endcase
        end
    endtask

    // Apply inputs for one clock, advance model, compare after the edge.
    task automatic cycle(input logic st, input logic iv, input logic [31:0] d,
                         input logic sr, input logic rn);
        u_if.start     = st;
        u_if.in_valid  = iv;
        u_if.in_data   = d;
        u_if.sig_ready = sr;
        rst_n          = rn;
        model_step(st, iv, d, sr, rn);
        @(posedge clk_in);
        #1;
        chk("in_ready",    {31'b0, u_if.in_ready},  {31'b0, m_mode == 1});
        chk("sig_valid",   {31'b0, u_if.sig_valid}, {31'b0, m_mode == 2});
        chk("busy",        {31'b0, u_if.busy},      {31'b0, m_mode != 0});
        chk("overrun",     {31'b0, u_if.overrun},   {31'b0, m_ovr});
        chk("sig_data",    u_if.sig_data,           ref_sig());
        chk("lane_active", {28'b0, u_if.sig_lane_active}, {28'b0, ref_act()});
    endtask

    task automatic idle_cyc();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic word(input logic [31:0] d);
        cycle(1'b0, 1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic go();
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic alt_window();
        word(32'h01020304);
        word(32'h0);
        word(32'h0);
        word(32'h0);
    endtask

    logic [31:0] held;

    initial begin
        m_mode = 0;
        m_ovr  = 1'b0;
        u_if.start = 1'b0; u_if.in_valid = 1'b0; u_if.in_data = '0; u_if.sig_ready = 1'b0;
        rst_n = 1'b0;

        // reset state
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        chk("reset_data", u_if.sig_data, 32'h0);

        // alternating pattern, back-to-back
        go();
        alt_window();
        chk("alt_sig",    u_if.sig_data, 32'h08101820);
        chk("alt_active", {28'b0, u_if.sig_lane_active}, 32'hF);
        chk("alt_valid",  {31'b0, u_if.sig_valid}, 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("alt_hold",   u_if.sig_data, 32'h08101820);

        // constant window
        go();
        repeat (WL) word(32'hFFFFFFFF);
        chk("const_sig",    u_if.sig_data, 32'h0);
        chk("const_active", {28'b0, u_if.sig_lane_active}, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // backpressure with words offered during REPORT
        go();
        alt_window();
        held = u_if.sig_data;
        repeat (5) cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b1);
        chk("bp_stable",  u_if.sig_data, held);
        chk("bp_overrun", {31'b0, u_if.overrun}, 32'h1);
        chk("bp_ready",   {31'b0, u_if.in_ready}, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("bp_idle",    {31'b0, u_if.busy}, 32'h0);
        go();
        chk("bp_ovr_clr", {31'b0, u_if.overrun}, 32'h0);

        // bubbles
        cycle(1'b0, 1'b0, $urandom, 1'b0, 1'b1);
        word(32'h01020304);
        cycle(1'b0, 1'b0, $urandom, 1'b0, 1'b1);
        word(32'h0);
        cycle(1'b0, 1'b0, $urandom, 1'b0, 1'b1);
        word(32'h0);
        cycle(1'b0, 1'b0, $urandom, 1'b0, 1'b1);
        word(32'h0);
        chk("bubble_sig", u_if.sig_data, 32'h08101820);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // restart mid-window, including a word coincident with start
        go();
        word($urandom);
        word($urandom);
        cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b1);
        alt_window();
        chk("restart_sig", u_if.sig_data, 32'h08101820);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // reset mid-window and mid-REPORT
        go();
        word($urandom);
        word($urandom);
        cycle(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
        chk("rst_mid_busy", {31'b0, u_if.busy}, 32'h0);
        repeat (3) word($urandom);
        chk("no_start_data", u_if.sig_data, 32'h0);
        go();
        alt_window();
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_rep_valid", {31'b0, u_if.sig_valid}, 32'h0);
        chk("rst_rep_ovr",   {31'b0, u_if.overrun}, 32'h0);
        idle_cyc();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        st, iv, sr, rn;
            logic [31:0] d;
            rn = ($urandom_range(0, 99) != 0);
            st = ($urandom_range(0, 14) == 0);
            iv = ($urandom_range(0, 3) != 0);
            sr = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       d = 32'h0;
                1:       d = 32'h5A5A5A5A;
                default: d = $urandom;
            endcase
            cycle(st, iv, d, sr, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_path_result_monitor
`default_nettype wire
